// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes and the datapath mux/ALU select values driven by the controller.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEI,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH,
        TRAP
    } mc_state;

    typedef enum logic [6:0] {
        lw   = 7'b0000011,
        addi = 7'b0010011,
        sw   = 7'b0100011,
        bne  = 7'b1100011
    } opcode;

    typedef enum logic [1:0] {
        Imm    = 2'd0,
        Store  = 2'd1,
        Branch = 2'd2
    } instr_format;

    typedef enum logic {
        Sum = 1'b0,
        Sub = 1'b1
    } alu_ctrl;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'd0,
        SRC_A_OLDPC = 2'd1,
        SRC_A_RS1   = 2'd2
    } src_a_sel;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } src_b_sel;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'd0,
        RES_MEMDATA = 2'd1,
        RES_ALU     = 2'd2
    } result_sel;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_BUS     = 2'd2;

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle in which the
// outstanding request would reach TIMEOUT_CYCLES unanswered.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int WAIT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every register it samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (waiting && (count_q != LIMIT)) begin
            count_q <= count_q + WAIT_W'(1);
        end
    end

    // Fires on the wait cycle that brings the count to the limit; a ready in
    // that same cycle drops 'waiting' and so wins over the timeout.
    assign timeout = waiting && (count_q >= LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Sequencer for the multi-cycle RV32I core: walks the shared datapath through
// fetch/decode/execute/memory/writeback and traps on bad opcodes or bus stalls.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int WAIT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        EQ,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        ALUctrl,
    output logic [1:0]  ALUsrcA,
    output logic [1:0]  ALUsrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    mc_state     state_q;
    logic [1:0]  cause_q;
    logic [6:0]  op;
    logic        timeout;
    logic        unused_instr_bits;

    assign op                = instr[6:0];
    assign unused_instr_bits = ^instr[31:7];

    // Idle and handshake-complete cycles both restart the count, which covers
    // every entry into FETCH, MEMRD and MEMWR.
    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .WAIT_W         (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!mem_req || mem_ready),
        .waiting (mem_req && !mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            cause_q <= TRAP_NONE;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ready) begin
                        state_q <= DECODE;
                    end else if (timeout) begin
                        state_q <= TRAP;
                        cause_q <= TRAP_BUS;
                    end
                end
                DECODE: begin
                    case (op)
                        addi:    state_q <= EXEI;
                        lw, sw:  state_q <= MEMADR;
                        bne:     state_q <= BRANCH;
                        default: begin
                            state_q <= TRAP;
                            cause_q <= TRAP_ILLEGAL;
                        end
                    endcase
                end
                EXEI:   state_q <= ALUWB;
                ALUWB:  state_q <= FETCH;
                MEMADR: state_q <= (op == lw) ? MEMRD : MEMWR;
                MEMRD: begin
                    if (mem_ready) begin
                        state_q <= MEMWB;
                    end else if (timeout) begin
                        state_q <= TRAP;
                        cause_q <= TRAP_BUS;
                    end
                end
                MEMWB:  state_q <= FETCH;
                MEMWR: begin
                    if (mem_ready) begin
                        state_q <= FETCH;
                    end else if (timeout) begin
                        state_q <= TRAP;
                        cause_q <= TRAP_BUS;
                    end
                end
                BRANCH: state_q <= FETCH;
                TRAP:   state_q <= TRAP;
                default: begin
                    state_q <= TRAP;
                    cause_q <= TRAP_ILLEGAL;
                end
            endcase
        end
    end

    // NOTE: every output gets its 0 default before the case so no path leaves
    // one unassigned (no latches); gating on rst drops mem_req the instant
    // reset rises, without waiting for a clock edge.
    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUctrl   = Sum;
        ALUsrcA   = SRC_A_PC;
        ALUsrcB   = SRC_B_RS2;
        ImmSrc    = Imm;
        ResultSrc = RES_ALUOUT;
        retire    = 1'b0;
        trap      = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        ALUsrcB   = SRC_B_FOUR;
                        ResultSrc = RES_ALU;
                    end
                end
                DECODE: begin
                    ALUsrcA = SRC_A_OLDPC;
                    ALUsrcB = SRC_B_IMM;
                    ImmSrc  = Branch;
                end
                EXEI: begin
                    ALUsrcA = SRC_A_RS1;
                    ALUsrcB = SRC_B_IMM;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                MEMADR: begin
                    ALUsrcA = SRC_A_RS1;
                    ALUsrcB = SRC_B_IMM;
                    ImmSrc  = (op == sw) ? Store : Imm;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                MEMWB: begin
                    RegWrite  = 1'b1;
                    ResultSrc = RES_MEMDATA;
                    retire    = 1'b1;
                end
                MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    AdrSrc    = 1'b1;
                    retire    = mem_ready;
                end
                BRANCH: begin
                    ALUsrcA = SRC_A_RS1;
                    ALUctrl = Sub;
                    PCWrite = !EQ;
                    retire  = 1'b1;
                end
                TRAP:    trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction-level bench: each instruction is expanded into its
// expected per-cycle control outputs and compared cycle by cycle with the DUT.
module tb_multicycle_control_fsm;

    localparam int TO       = 4;
    localparam int N_RANDOM = 300;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       alu_sub;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] imm_src;
        logic [1:0] result_src;
        logic       retire;
        logic       trap;
        logic [1:0] cause;
    } ctl_t;

    localparam int K_ADDI = 0, K_LW = 1, K_SW = 2, K_BNE = 3, K_ILL = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [31:0] instr     = '0;
    logic        EQ        = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, AdrSrc, IRWrite, PCWrite, RegWrite, ALUctrl;
    logic [1:0]  ALUsrcA, ALUsrcB, ImmSrc, ResultSrc;
    logic        retire, trap;
    logic [1:0]  trap_cause;
    ctl_t        obs;

    logic [6:0]  illegal_ops [4] = '{7'h7f, 7'h33, 7'h37, 7'h6f};
    logic [6:0]  legal_ops   [4] = '{7'h13, 7'h03, 7'h23, 7'h63};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(
        .TIMEOUT_CYCLES (TO),
        .WAIT_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .EQ         (EQ),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUctrl    (ALUctrl),
        .ALUsrcA    (ALUsrcA),
        .ALUsrcB    (ALUsrcB),
        .ImmSrc     (ImmSrc),
        .ResultSrc  (ResultSrc),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    assign obs = {mem_req, mem_write, AdrSrc, IRWrite, PCWrite, RegWrite, ALUctrl,
                  ALUsrcA, ALUsrcB, ImmSrc, ResultSrc, retire, trap, trap_cause};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive inputs on the falling edge, compare just after.
    task automatic step(string tag, ctl_t exp, logic ready, logic eq);
        @(negedge clk);
        mem_ready = ready;
        EQ        = eq;
        #1 check(tag, 32'(obs), 32'(exp));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must be 0 before any edge.
    task automatic do_reset(string tag);
        #1 rst = 1'b1;
        mem_ready = rbit();
        EQ        = rbit();
        #1 check(tag, 32'(obs), 32'd0);
        @(posedge clk);
        #1 check(tag, 32'(obs), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // A request held for 'waits' unanswered cycles; TO of them means timeout.
    task automatic mem_phase(string tag, ctl_t wait_v, ctl_t done_v, int waits,
                             output bit timed_out);
        timed_out = 1'b1;
        for (int w = 0; w < TO; w++) begin
            if (w == waits) begin
                step(tag, done_v, 1'b1, rbit());
                timed_out = 1'b0;
                break;
            end
            step(tag, wait_v, 1'b0, rbit());
        end
    endtask

    task automatic trap_phase(int cause, int n);
        ctl_t v = '0;
        v.trap  = 1'b1;
        v.cause = cause[1:0];
        for (int i = 0; i < n; i++) step("trap_hold", v, rbit(), rbit());
        do_reset("reset_from_trap");
    endtask

    task automatic run_instr(int kind, int fw, int mw, bit eq, int trap_cycles);
        ctl_t v, d;
        bit   to;
        instr = $urandom;
        instr[6:0] = (kind == K_ILL) ? illegal_ops[$urandom_range(0, 3)] : legal_ops[kind];

        v = '0; v.mem_req = 1'b1;
        d = v; d.ir_write = 1'b1; d.pc_write = 1'b1; d.src_b = 2'd2; d.result_src = 2'd2;
        mem_phase("fetch", v, d, fw, to);
        if (to) begin
            trap_phase(2, trap_cycles);
            return;
        end

        v = '0; v.src_a = 2'd1; v.src_b = 2'd1; v.imm_src = 2'd2;
        step("decode", v, rbit(), rbit());
        if (kind == K_ILL) begin
            trap_phase(1, trap_cycles);
            return;
        end

        case (kind)
            K_ADDI: begin
                v = '0; v.src_a = 2'd2; v.src_b = 2'd1;
                step("exei", v, rbit(), rbit());
                v = '0; v.reg_write = 1'b1; v.retire = 1'b1;
                step("aluwb", v, rbit(), rbit());
            end
            K_LW, K_SW: begin
                v = '0; v.src_a = 2'd2; v.src_b = 2'd1; v.imm_src = (kind == K_SW) ? 2'd1 : 2'd0;
                step("memadr", v, rbit(), rbit());
                v = '0; v.mem_req = 1'b1; v.adr_src = 1'b1; v.mem_write = (kind == K_SW);
                d = v; d.retire = (kind == K_SW);
                mem_phase((kind == K_SW) ? "memwr" : "memrd", v, d, mw, to);
                if (to) begin
                    trap_phase(2, trap_cycles);
                    return;
                end
                if (kind == K_LW) begin
                    v = '0; v.reg_write = 1'b1; v.result_src = 2'd1; v.retire = 1'b1;
                    step("memwb", v, rbit(), rbit());
                end
            end
            default: begin
                v = '0; v.src_a = 2'd2; v.alu_sub = 1'b1; v.pc_write = !eq; v.retire = 1'b1;
                step("branch", v, rbit(), eq);
            end
        endcase
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 2))
                                           : int'($urandom_range(0, TO - 1));
    endfunction

    initial begin
        ctl_t v;
        do_reset("reset");

        run_instr(K_ADDI, 0, 0, 1'b0, 0);
        run_instr(K_LW,   0, 3, 1'b0, 0);
        run_instr(K_BNE,  0, 0, 1'b0, 0);
        run_instr(K_BNE,  0, 0, 1'b1, 0);
        run_instr(K_ILL,  0, 0, 1'b0, 20);
        run_instr(K_SW,   0, TO, 1'b0, 3);
        run_instr(K_SW,   0, TO - 1, 1'b0, 0);
        run_instr(K_ADDI, TO, 0, 1'b0, 3);
        run_instr(K_LW,   2, TO, 1'b0, 2);

        // Reset dropped in the middle of a store's bus transaction.
        instr = $urandom;
        instr[6:0] = 7'h23;
        v = '0; v.mem_req = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1; v.src_b = 2'd2; v.result_src = 2'd2;
        step("fetch", v, 1'b1, 1'b0);
        v = '0; v.src_a = 2'd1; v.src_b = 2'd1; v.imm_src = 2'd2;
        step("decode", v, 1'b0, 1'b0);
        v = '0; v.src_a = 2'd2; v.src_b = 2'd1; v.imm_src = 2'd1;
        step("memadr", v, 1'b0, 1'b0);
        v = '0; v.mem_req = 1'b1; v.mem_write = 1'b1; v.adr_src = 1'b1;
        step("memwr", v, 1'b0, 1'b0);
        do_reset("rst_mid_memwr");
        run_instr(K_ADDI, 1, 0, 1'b0, 0);

        for (int i = 0; i < N_RANDOM; i++) begin
            int r, kind;
            r = int'($urandom_range(0, 19));
            kind = (r < 5) ? K_ADDI : (r < 10) ? K_LW : (r < 14) ? K_SW : (r < 18) ? K_BNE : K_ILL;
            run_instr(kind, rand_wait(), rand_wait(), rbit(), int'($urandom_range(1, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
